// File: rtl/vote_gray_encrypt_tx.sv
// Snapshots a candidate vote tally on start and streams each count Gray-encoded over valid/ready.
// Optional out_parity port (even parity of out_data) is enabled by defining EVM_ENC_PARITY_EN.
module vote_gray_encrypt_tx #(
   parameter  int WIDTH    = 8,
   parameter  int NUM_CAND = 4,
   localparam int IDX_W    = $clog2(NUM_CAND)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [NUM_CAND*WIDTH-1:0] counts_in,
   output logic                      busy,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [IDX_W-1:0]          out_idx,
   output logic                      out_last,
   output logic                      done
`ifdef EVM_ENC_PARITY_EN
   ,output logic                     out_parity
`endif
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] snap [NUM_CAND];
   logic             load;
   logic             busy_n, valid_n, last_n, done_n;
   logic [WIDTH-1:0] data_n;
   logic [IDX_W-1:0] idx_n, idx_inc;

   function automatic logic [WIDTH-1:0] gray(input logic [WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         for (int unsigned i = 0; i < NUM_CAND; i++) snap[i] <= '0;
      end else begin
         state     <= state_n;
         busy      <= busy_n;
         out_valid <= valid_n;
         out_data  <= data_n;
         out_idx   <= idx_n;
         out_last  <= last_n;
         done      <= done_n;
         if (load) begin
            for (int unsigned i = 0; i < NUM_CAND; i++) snap[i] <= counts_in[i*WIDTH +: WIDTH];
         end
      end
   end

`ifdef EVM_ENC_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_parity <= 1'b0;
      else        out_parity <= ^data_n;
   end
`endif

   always_comb begin
      state_n = state;
      busy_n  = busy;
      valid_n = out_valid;
      data_n  = out_data;
      idx_n   = out_idx;
      last_n  = out_last;
      done_n  = 1'b0;
      load    = 1'b0;
      idx_inc = out_idx + IDX_W'(1);
      case (state)
         IDLE: begin
            busy_n = 1'b0;
            if (start) begin
               // First word comes straight from the input; the snapshot lands on the same edge.
               load    = 1'b1;
               state_n = SEND;
               busy_n  = 1'b1;
               valid_n = 1'b1;
               idx_n   = '0;
               data_n  = gray(counts_in[0 +: WIDTH]);
               last_n  = 1'b0;
            end
         end
         SEND: begin
            if (out_valid && out_ready) begin
               if (out_idx == LAST_IDX) begin
                  state_n = DONE;
                  valid_n = 1'b0;
                  last_n  = 1'b0;
                  done_n  = 1'b1;
               end else begin
                  idx_n  = idx_inc;
                  data_n = gray(snap[idx_inc]);
                  last_n = (idx_inc == LAST_IDX);
               end
            end
         end
         DONE: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            valid_n = 1'b0;
            last_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_vote_gray_encrypt_tx.sv
// Scoreboard bench for vote_gray_encrypt_tx (WIDTH=8, NUM_CAND=4); parity checked when EVM_ENC_PARITY_EN is set.
module tb_vote_gray_encrypt_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] counts_in = '0;
   logic        busy, out_valid, out_last, done;
   logic [7:0]  out_data;
   logic [1:0]  out_idx;
`ifdef EVM_ENC_PARITY_EN
   logic        out_parity;
`endif

   int compared = 0;
   int mismatched = 0;
   int xfers = 0;

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] idx;
      logic       last;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   vote_gray_encrypt_tx #(.WIDTH(8), .NUM_CAND(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .counts_in (counts_in),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .done      (done)
`ifdef EVM_ENC_PARITY_EN
      ,.out_parity (out_parity)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] gray_of(input logic [7:0] b);
      logic [7:0] g;
      g[7] = b[7];
      for (int k = 0; k < 7; k++) g[k] = b[k+1] ^ b[k];
      return g;
   endfunction

   task automatic push_words(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         e.data = w[i*8 +: 8];
         e.idx  = 2'(i);
         e.last = (i == 3);
         sb.push_back(e);
      end
   endtask

   task automatic push_counts(input logic [31:0] c);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[i*8 +: 8] = gray_of(c[i*8 +: 8]);
      push_words(w);
   endtask

   // Returns 1 ns after the edge that accepted start.
   task automatic kick(input logic [31:0] c);
      @(posedge clk); #1;
      counts_in = c;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         xfers++;
         if (sb.size() == 0) begin
            chk("sb_extra_word", 32'd1, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("data", 32'(out_data), 32'(mon_e.data));
            chk("idx",  32'(out_idx),  32'(mon_e.idx));
            chk("last", 32'(out_last), 32'(mon_e.last));
`ifdef EVM_ENC_PARITY_EN
            chk("parity", 32'(out_parity), 32'(^mon_e.data));
`endif
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit bad;
      #12;
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last",  32'(out_last),  32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_idx",   32'(out_idx),   32'd0);
`ifdef EVM_ENC_PARITY_EN
      chk("rst_parity", 32'(out_parity), 32'd0);
`endif
      #1 rst_n = 1'b1;

      // Basic encode with cycle-accurate control outputs
      out_ready = 1'b1;
      push_words(32'h80030100);
      kick(32'hFF020100);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         chk($sformatf("t1_valid_c%0d", c), 32'(out_valid), 32'((c >= 1) && (c <= 4)));
         chk($sformatf("t1_last_c%0d", c),  32'(out_last),  32'(c == 4));
         chk($sformatf("t1_done_c%0d", c),  32'(done),      32'(c == 5));
         chk($sformatf("t1_busy_c%0d", c),  32'(busy),      32'(c <= 5));
      end
      chk("t1_sb_empty", 32'(sb.size()), 32'd0);

      // Boundary values
      push_words(32'hFF07C040);
      kick(32'hAA05807F);
      wait_done("t2_done");
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);

      // Backpressure at idx 1
      out_ready = 1'b0;
      xfers = 0;
      push_counts(32'h44330210);
      kick(32'h44330210);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_data",  32'(out_data),  32'h03);
         chk("bp_idx",   32'(out_idx),   32'd1);
         chk("bp_valid", 32'(out_valid), 32'd1);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_done("t3_done");
      chk("bp_xfers", 32'(xfers), 32'd4);
      chk("t3_sb_empty", 32'(sb.size()), 32'd0);

      // Start while busy plus input change after capture
      push_counts(32'h9C5A3C01);
      kick(32'h9C5A3C01);
      @(posedge clk);
      @(posedge clk); #1;
      chk("t4_idx2", 32'(out_idx), 32'd2);
      start = 1'b1;
      counts_in = 32'h11111111;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t4_done");
      bad = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (out_valid || busy) bad = 1'b1;
      end
      chk("t4_no_restart", 32'(bad), 32'd0);
      chk("t4_sb_empty", 32'(sb.size()), 32'd0);

      // Reset mid-stream at idx 2 under backpressure
      push_counts(32'h12345678);
      kick(32'h12345678);
      @(posedge clk);
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("t5_pre_idx",   32'(out_idx),   32'd2);
      chk("t5_pre_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_busy",  32'(busy),      32'd0);
      chk("t5_rst_idx",   32'(out_idx),   32'd0);
      chk("t5_rst_done",  32'(done),      32'd0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      bad = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (done || out_valid) bad = 1'b1;
      end
      chk("t5_no_done", 32'(bad), 32'd0);
      out_ready = 1'b1;
      push_counts(32'hF00F5AA5);
      kick(32'hF00F5AA5);
      @(negedge clk);
      chk("t5_fresh_idx",   32'(out_idx),   32'd0);
      chk("t5_fresh_valid", 32'(out_valid), 32'd1);
      wait_done("t5_done");
      chk("t5_sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
